// File: rtl/fifo_bit_serializer_pkg.sv
// fifo_bit_serializer_pkg: shared FSM encoding and width helper for the FIFO/serializer pair
package fifo_bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of bits needed to hold the value v, never less than one
    function automatic int clogb2(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_bit_serializer.sv
// fifo_bit_serializer: pops words from a show-ahead FIFO and streams them out one bit per handshake
module fifo_bit_serializer
    import fifo_bit_serializer_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_MSB_FIRST  = 1,
    parameter int C_CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [C_DATA_WIDTH-1:0] fifo_dout,
    output logic                    fifo_rd_en,
    output logic                    ser_valid,
    input  logic                    ser_ready,
    output logic                    ser_dout,
    output logic                    ser_last,
    output logic                    busy,
    output logic [C_CNT_WIDTH-1:0]  word_count
);

    localparam int W = C_DATA_WIDTH;
    localparam int CW = clogb2(W - 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t               state, state_nxt;
    logic [W-1:0]         sr, sr_nxt;
    logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [C_CNT_WIDTH-1:0] word_count_nxt;
    logic                 hs, last_hs, load;

    assign hs         = (state == ST_SHIFT) & ser_ready;
    assign last_hs    = hs & (bit_cnt == LAST);
    // Reset gating keeps the pop strobe quiet while the FSM is held in IDLE by rst_n
    assign load       = rst_n & enable & ~fifo_empty & ((state == ST_IDLE) | last_hs);
    assign fifo_rd_en = load;
    assign ser_valid  = (state == ST_SHIFT);
    assign busy       = ser_valid;
    assign ser_dout   = (C_MSB_FIRST != 0) ? sr[W-1] : sr[0];
    assign ser_last   = ser_valid & (bit_cnt == LAST);

    // Next state: a load wins over going idle so consecutive words leave no bubble
    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        bit_cnt_nxt    = bit_cnt;
        word_count_nxt = word_count + C_CNT_WIDTH'(last_hs);
        if (load) begin
            state_nxt   = ST_SHIFT;
            sr_nxt      = fifo_dout;
            bit_cnt_nxt = '0;
        end else if (last_hs) begin
            state_nxt   = ST_IDLE;
            sr_nxt      = '0;
            bit_cnt_nxt = '0;
        end else if (hs) begin
            sr_nxt      = (C_MSB_FIRST != 0) ? {sr[W-2:0], 1'b0} : {1'b0, sr[W-1:1]};
            bit_cnt_nxt = bit_cnt + CW'(1);
        end
    end

    // State, shift register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            bit_cnt    <= bit_cnt_nxt;
            word_count <= word_count_nxt;
        end
    end

endmodule
